mix_engine: RTL and testbench

Parametrised, handshaked multi-lane mixing engine. It replaces the fixed 8×32-bit, free-running per-edge mixer with a block that has configurable lane count, lane width and a per-job round count. A job is loaded through a valid/ready input port and executed one round per cycle. The result is held on a valid/ready output port until it is consumed. The block sits between a seed source and any consumer of pseudo-random or scrambled lane data.

---
 rtl/mix_pkg.sv | 22 ++
 rtl/mix_round.sv | 44 ++++
 rtl/mix_engine.sv | 101 ++++++++++
 tb/tb_mix_engine.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mix_pkg.sv
// mix_pkg: shared types and helpers for the mix_engine block.
//   state_t    - engine FSM states (IDLE, RUN, DONE)
//   lane_lsb   - bit offset of a lane inside a packed lane vector
//   mult_const - per-lane odd multiplier used in the final mixing step
package mix_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

  // Always odd, so the multiply is a bijection mod 2^WIDTH.
  function automatic int mult_const(input int lane);
    return 2 * lane + 3;
  endfunction

endpackage

// File: rtl/mix_round.sv
// mix_round: one purely combinational mixing round over all lanes.
// Ports:
//   lanes      in  LANES*WIDTH  current lane state, lane i at [i*WIDTH +: WIDTH]
//   r          in  WIDTH        round index, added into every lane
//   next_lanes out LANES*WIDTH  lane state after this round
module mix_round
  import mix_pkg::*;
#(
  parameter int LANES = 8,
  parameter int WIDTH = 32
) (
  input  logic [LANES*WIDTH-1:0] lanes,
  input  logic [WIDTH-1:0]       r,
  output logic [LANES*WIDTH-1:0] next_lanes
);

  logic [WIDTH-1:0] s [LANES];
  logic [WIDTH-1:0] t [LANES];
  logic [WIDTH-1:0] u [LANES];

  // Add lane index, ripple-accumulate (seeded by the last lane), cross-fold
  // each lane with the lane half a ring away, then multiply by an odd
  // constant and add the round index. The ripple is the critical path.
  always_comb begin
    s = '{default: '0};
    t = '{default: '0};
    u = '{default: '0};
    next_lanes = '0;
    for (int i = 0; i < LANES; i++) begin
      s[i] = lanes[lane_lsb(i, WIDTH) +: WIDTH] + WIDTH'(i);
    end
    t[0] = s[0] + s[LANES-1];
    for (int i = 1; i < LANES; i++) begin
      t[i] = s[i] + t[i-1];
    end
    for (int i = 0; i < LANES; i++) begin
      u[i] = t[i] ^ (t[(i + LANES/2) % LANES] << (WIDTH/2));
    end
    for (int i = 0; i < LANES; i++) begin
      next_lanes[lane_lsb(i, WIDTH) +: WIDTH] = u[i] * WIDTH'(mult_const(i)) + r;
    end
  end

endmodule

// File: rtl/mix_engine.sv
// mix_engine: handshaked multi-lane mixing engine.
// A job (seed + round count) is accepted on the in_* port, mixed one round
// per cycle, then held on the out_* port until consumed.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   in_valid   job offered            in_ready  job accepted this cycle
//   in_data    seed lanes             in_rounds rounds (saturated to MAX_ROUNDS)
//   out_valid  result held            out_ready consumer takes result
//   out_data   result lanes           busy      high while rounds execute
module mix_engine
  import mix_pkg::*;
#(
  parameter  int LANES      = 8,
  parameter  int WIDTH      = 32,
  parameter  int MAX_ROUNDS = 16,
  localparam int RW         = $clog2(MAX_ROUNDS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [RW-1:0]          in_rounds,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic                   busy
);

  state_t                 state, next_state;
  logic [LANES*WIDTH-1:0] lanes;
  logic [LANES*WIDTH-1:0] round_lanes;
  logic [RW-1:0]          cnt;
  logic [RW-1:0]          cnt_inc;
  logic [RW-1:0]          target;
  logic [RW-1:0]          sat_rounds;
  logic [WIDTH-1:0]       round_r;
  logic                   accept;

  // A new job may load while a finished result is being consumed, which
  // gives back-to-back operation without an idle bubble. This is the only
  // combinational output path and it depends on out_ready alone.
  assign in_ready   = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept     = in_valid && in_ready;
  assign sat_rounds = (in_rounds > RW'(MAX_ROUNDS)) ? RW'(MAX_ROUNDS) : in_rounds;
  assign cnt_inc    = cnt + RW'(1);
  assign round_r    = WIDTH'(cnt);

  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);
  assign out_data  = lanes;

  mix_round #(
    .LANES(LANES),
    .WIDTH(WIDTH)
  ) u_round (
    .lanes     (lanes),
    .r         (round_r),
    .next_lanes(round_lanes)
  );

  // Next-state decode; a zero-round job goes straight to DONE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) next_state = (sat_rounds == '0) ? DONE : RUN;
      end
      RUN: begin
        if (cnt_inc == target) next_state = DONE;
      end
      DONE: begin
        if (accept)         next_state = (sat_rounds == '0) ? DONE : RUN;
        else if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State, lane registers and round bookkeeping. Reset discards any
  // in-flight job so its result is never presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      lanes  <= '0;
      cnt    <= '0;
      target <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        lanes  <= in_data;
        cnt    <= '0;
        target <= sat_rounds;
      end else if (state == RUN) begin
        lanes <= round_lanes;
        cnt   <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_mix_engine.sv
// tb_mix_engine: directed self-checking bench for mix_engine with
// LANES=4, WIDTH=8, MAX_ROUNDS=16.
module tb_mix_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_rounds;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  mix_engine #(
    .LANES(4),
    .WIDTH(8),
    .MAX_ROUNDS(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_rounds(in_rounds),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  // Reference round for 4 lanes of 8 bits, written out lane by lane.
  function automatic logic [31:0] model_round(input logic [31:0] v, input int r);
    logic [7:0] a [4];
    logic [7:0] b [4];
    logic [7:0] c [4];
    logic [7:0] rr;
    rr = 8'(r);
    for (int i = 0; i < 4; i++) a[i] = v[8*i +: 8] + 8'(i);
    b[0] = a[0] + a[3];
    b[1] = a[1] + b[0];
    b[2] = a[2] + b[1];
    b[3] = a[3] + b[2];
    c[0] = b[0] ^ {b[2][3:0], 4'h0};
    c[1] = b[1] ^ {b[3][3:0], 4'h0};
    c[2] = b[2] ^ {b[0][3:0], 4'h0};
    c[3] = b[3] ^ {b[1][3:0], 4'h0};
    return {8'(c[3] * 8'd9 + rr), 8'(c[2] * 8'd7 + rr),
            8'(c[1] * 8'd5 + rr), 8'(c[0] * 8'd3 + rr)};
  endfunction

  function automatic logic [31:0] model_run(input logic [31:0] seed, input int rounds);
    logic [31:0] v;
    v = seed;
    for (int k = 0; k < rounds; k++) v = model_round(v, k);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_rounds = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    n_compared++; if (in_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
    n_compared++; if (out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
    n_compared++; if (out_data !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_out_data got %h want 0", out_data); end
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_single_round();
    in_valid = 1'b1; in_data = 32'h0; in_rounds = 5'd1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    n_compared++; if (busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL r1_busy got %b want 1", busy); end
    n_compared++; if (out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL r1_early_valid got %b want 0", out_valid); end
    tick();
    n_compared++; if (out_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL r1_valid got %b want 1", out_valid); end
    n_compared++; if (out_data !== 32'h917AE429) begin n_mismatched++; $display("[TB] FAIL r1_data got %h want 917ae429", out_data); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_compared++; if (out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL r1_consumed got %b want 0", out_valid); end
  endtask

  task automatic test_pass_through();
    in_valid = 1'b1; in_data = 32'h03020100; in_rounds = 5'd0; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL r0_busy got %b want 0", busy); end
    n_compared++; if (out_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL r0_valid got %b want 1", out_valid); end
    n_compared++; if (out_data !== 32'h03020100) begin n_mismatched++; $display("[TB] FAIL r0_data got %h want 03020100", out_data); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL r0_busy_after got %b want 0", busy); end
  endtask

  task automatic test_hold();
    logic [31:0] exp;
    int n;
    exp = model_run(32'h12345678, 5);
    in_valid = 1'b1; in_data = 32'h12345678; in_rounds = 5'd5; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    n_compared++; if (n !== 5) begin n_mismatched++; $display("[TB] FAIL r5_latency got %0d want 5", n); end
    // Offer a competing pass-through job while the result is held.
    in_valid = 1'b1; in_data = 32'hCAFEF00D; in_rounds = 5'd0;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_compared++; if (out_data !== exp) begin n_mismatched++; $display("[TB] FAIL hold_data[%0d] got %h want %h", k, out_data, exp); end
      n_compared++; if (in_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL hold_in_ready[%0d] got %b want 0", k, in_ready); end
      n_compared++; if (out_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL hold_valid[%0d] got %b want 1", k, out_valid); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_compared++; if (out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL hold_release got %b want 0", out_valid); end
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL hold_no_capture got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    exp = model_run(32'h89ABCDEF, 2);
    in_valid = 1'b1; in_data = 32'h0; in_rounds = 5'd1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    n_compared++; if (out_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b_first_valid got %b want 1", out_valid); end
    in_valid = 1'b1; in_data = 32'h89ABCDEF; in_rounds = 5'd2;
    #1;
    n_compared++; if (in_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b_in_ready got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_compared++; if (busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b_busy1 got %b want 1", busy); end
    n_compared++; if (out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL b2b_valid1 got %b want 0", out_valid); end
    tick();
    n_compared++; if (busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b_busy2 got %b want 1", busy); end
    tick();
    n_compared++; if (out_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b_valid3 got %b want 1", out_valid); end
    n_compared++; if (out_data !== exp) begin n_mismatched++; $display("[TB] FAIL b2b_data got %h want %h", out_data, exp); end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_saturation();
    logic [31:0] exp;
    int n;
    exp = model_run(32'hA5C30F11, 16);
    in_valid = 1'b1; in_data = 32'hA5C30F11; in_rounds = 5'd19; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    n_compared++; if (n !== 16) begin n_mismatched++; $display("[TB] FAIL sat_rounds got %0d want 16", n); end
    n_compared++; if (out_data !== exp) begin n_mismatched++; $display("[TB] FAIL sat_data got %h want %h", out_data, exp); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int seen;
    in_valid = 1'b1; in_data = 32'hDEADBEEF; in_rounds = 5'd8; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_compared++; if (out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midrst_valid got %b want 0", out_valid); end
    n_compared++; if (out_data !== 32'h0) begin n_mismatched++; $display("[TB] FAIL midrst_data got %h want 0", out_data); end
    n_compared++; if (in_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL midrst_in_ready got %b want 1", in_ready); end
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midrst_busy got %b want 0", busy); end
    seen = 0;
    for (int k = 0; k < 10; k++) begin tick(); if (out_valid) seen++; end
    n_compared++; if (seen !== 0) begin n_mismatched++; $display("[TB] FAIL midrst_ghost got %0d want 0", seen); end
    in_valid = 1'b1; in_data = 32'h0; in_rounds = 5'd1;
    tick();
    in_valid = 1'b0;
    tick();
    n_compared++; if (out_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL postrst_valid got %b want 1", out_valid); end
    n_compared++; if (out_data !== 32'h917AE429) begin n_mismatched++; $display("[TB] FAIL postrst_data got %h want 917ae429", out_data); end
  endtask

  initial begin
    test_reset();
    test_single_round();
    test_pass_through();
    test_hold();
    test_back_to_back();
    test_saturation();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
